// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared defaults, window bit-offset helper and width constants for line_window_buffer
package line_buf_pkg;
  localparam int DEF_PIX_W = 12;
  localparam int DEF_LINE_LEN = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_K = 3;
  localparam int DEF_COL_W = $clog2(DEF_LINE_LEN);
  function automatic int win_idx(input int r, input int c, input int k, input int pw = DEF_PIX_W);
    return (r * k + c) * pw;
  endfunction
endpackage

// File: rtl/line_window_buffer_line_ram.sv
// line_ram: one line of pixel storage, written and read at the same column on each accepted pixel
//   CLOCK_50 clock; we_i write enable; addr_i column; wdata_i pixel to store;
//   rdata_o pixel stored at addr_i before this cycle's write (previous line)
module line_ram #(
  parameter int W = 12,
  parameter int DEPTH = 640,
  parameter int AW = 10
) (
  input  logic          CLOCK_50,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  (* ramstyle = "M10K" *) logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge CLOCK_50)
    if (we_i) mem_q[addr_i] <= wdata_i;
  // the write only lands at the edge, so this read returns the previous line's pixel
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: K-row line buffer turning a raster pixel stream into interior KxK windows
//   CLOCK_50/rst clock and synchronous active-high reset
//   in_data/in_valid/in_sof/in_ready pixel input handshake, in_sof marks pixel (0,0)
//   out_window/out_valid/out_ready window output handshake, pixel (r,c) at win_idx(r,c,K)
//   out_row/out_col position of the newest pixel, out_eof window holds the frame's last pixel
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int LINE_LEN = DEF_LINE_LEN,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K = DEF_K
) (
  input  logic                        CLOCK_50,
  input  logic                        rst,
  input  logic [PIX_W-1:0]            in_data,
  input  logic                        in_valid,
  input  logic                        in_sof,
  output logic                        in_ready,
  output logic [K*K*PIX_W-1:0]        out_window,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(IMG_H)-1:0]    out_row,
  output logic [$clog2(LINE_LEN)-1:0] out_col,
  output logic                        out_eof
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(LINE_LEN);
  logic acc, last_col, last_row;
  logic [RW-1:0] row_q, row_d, pos_row, orow_q, orow_d;
  logic [CW-1:0] col_q, col_d, pos_col, ocol_q, ocol_d;
  logic valid_q, valid_d, eof_q, eof_d;
  logic [K*K*PIX_W-1:0] win_q, win_d;
  logic [K-1:0][PIX_W-1:0] new_col;
  logic [K-2:0][PIX_W-1:0] rd;
  assign in_ready = !valid_q || out_ready;
  assign acc = in_valid && in_ready;
  assign pos_row = in_sof ? '0 : row_q;
  assign pos_col = in_sof ? '0 : col_q;
  assign last_col = pos_col == CW'(LINE_LEN - 1);
  assign last_row = pos_row == RW'(IMG_H - 1);
  assign new_col[K-1] = in_data;
  // memory i holds the line i+1 rows above the incoming one; each passes its old pixel down the chain
  for (genvar i = 0; i < K - 1; i++) begin : g_line
    logic [PIX_W-1:0] wd;
    if (i == 0) begin : g_head
      assign wd = in_data;
    end else begin : g_tail
      assign wd = rd[i-1];
    end
    line_ram #(.W(PIX_W), .DEPTH(LINE_LEN), .AW(CW)) u_ram (
      .CLOCK_50(CLOCK_50),
      .we_i    (acc),
      .addr_i  (pos_col),
      .wdata_i (wd),
      .rdata_o (rd[i])
    );
    assign new_col[K-2-i] = rd[i];
  end
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    eof_d = eof_q;
    win_d = win_q;
    valid_d = valid_q && !out_ready;
    if (acc) begin
      col_d = last_col ? '0 : pos_col + 1'b1;
      row_d = !last_col ? pos_row : last_row ? '0 : pos_row + 1'b1;
      orow_d = pos_row;
      ocol_d = pos_col;
      eof_d = last_col && last_row;
      // qualification follows the counters, so a restarted frame never exposes stale columns
      valid_d = pos_row >= RW'(K - 1) && pos_col >= CW'(K - 1);
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win_d[win_idx(r, c, K, PIX_W) +: PIX_W] = win_q[win_idx(r, c + 1, K, PIX_W) +: PIX_W];
        win_d[win_idx(r, K - 1, K, PIX_W) +: PIX_W] = new_col[r];
      end
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      eof_q <= 1'b0;
      valid_q <= 1'b0;
      win_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      eof_q <= eof_d;
      valid_q <= valid_d;
      win_q <= win_d;
    end
  end
  assign out_window = win_q;
  assign out_valid = valid_q;
  assign out_row = orow_q;
  assign out_col = ocol_q;
  assign out_eof = eof_q;
endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised K-row line buffer that turns a raster pixel stream into a sliding K×K window for convolution stages such as Sobel or Gaussian. Replaces the single-row, three-tap buffer with a configurable window height and width, and adds valid/ready handshakes on both sides. It adds frame tracking and emits only interior windows. It sits between the camera pixel stream and the convolution datapath.

## Interface
- PIX_W, 12, pixel width in bits
- LINE_LEN, 640, pixels per line
- IMG_H, 480, lines per frame
- K, 3, window size; legal 2..5
- CLOCK_50  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock CLOCK_50
- in_data  in  PIX_W  input pixel
- in_valid  in  1  in_data valid
- in_sof  in  1  start of frame; qualified by in_valid
- in_ready  out  1  block can accept a pixel
- out_window  out  K*K*PIX_W  window; pixel (r,c) at bits [(r*K+c)*PIX_W +: PIX_W]; r=0 is the oldest row, c=0 is the oldest column
- out_valid  out  1  out_window valid
- out_ready  in  1  downstream accepts the window
- out_row  out  $clog2(IMG_H)  row of the bottom-right (newest) pixel
- out_col  out  $clog2(LINE_LEN)  column of the bottom-right pixel
- out_eof  out  1  window contains the last pixel of the frame

## Operation
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready, combinational.
- Counters:
  - col counts 0..LINE_LEN-1, then wraps to 0 and increments row.
  - row counts 0..IMG_H-1, then wraps to 0 (implicit new frame).
  - An accepted pixel with in_sof is treated as position (0,0), and counting continues from there.
- Storage: K-1 line memories, each LINE_LEN×PIX_W.
  - On accept at column c, memory k reads column c and passes it to memory k+1 (chained). Memory 0 writes in_data.
  - Read-during-write to the same address returns the old data.
- Window: K×K shift register.
  - On accept, every row shifts left by one column.
  - The new column is {line memory outputs, oldest first; in_data last}.
- Output qualification: the window is valid only if the accepted pixel has row ≥ K-1 and col ≥ K-1. No padding: border windows are dropped.
- out_eof = 1 for the window whose bottom-right pixel is (IMG_H-1, LINE_LEN-1).
- in_sof mid-frame: counters restart. Stale shift-register contents are never emitted, because qualification restarts with the counters.

## Timing
- Latency: a pixel accepted in cycle t appears in the window in cycle t+1. out_valid rises in t+1 if the pixel qualifies.
- Throughput: one pixel per cycle while out_ready = 1.
- Backpressure: while out_valid && !out_ready, the following are frozen:
  - out_window, out_row, out_col, out_eof;
  - the counters and the line memories.
  - in_ready is low, so no pixel is lost or duplicated.
- If an accept is non-qualifying and the previous window has been consumed, out_valid falls in the next cycle.
- Reset values:
  - out_valid = 0, out_window = 0, out_row = 0, out_col = 0, out_eof = 0;
  - counters = 0; in_ready = 1 after reset.
- Line memory contents are not reset.
- rst mid-frame: outputs are cleared the next cycle, and the pixel after rst is treated as (0,0).

## Structure
- Package line_buf_pkg holds:
  - default PIX_W, LINE_LEN, IMG_H and K;
  - a function win_idx(r,c,K) returning the bit offset;
  - a clog2-based width constant.
- One sub-module, line_ram: single-port synchronous RAM with read-before-write and a M10K ramstyle attribute. It is instantiated K-1 times in a generate loop.

## Test plan
- Reset: assert rst for 2 cycles -> out_valid=0, out_window=0, in_ready=1.
- Ramp frame with K=3, LINE_LEN=8, IMG_H=6 and pixel = row*16+col, streamed continuously with out_ready=1:
  - first out_valid one cycle after pixel (2,2), window {0,1,2,16,17,18,32,33,34} (r-major, oldest first);
  - exactly 24 windows in total;
  - out_eof only on (5,7).
- Backpressure: same frame with out_ready held low 5 cycles mid-row -> in_ready=0 and outputs stable throughout; still 24 windows, in the same order with the same values.
- Mid-frame in_sof at row 3 -> no out_valid until new-frame pixel (2,2), whose window uses only new-frame pixels.
- K=5, same frame -> first window at (4,4); 4×2 = 8 windows in total.
- rst asserted mid-row 3 then a fresh frame -> out_valid low the cycle after rst; next window at (2,2), with correct values.
